// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock over a WIDTH+1-bit borrow chain.
// Optional SEQ_DIVIDER_ZERO_CHECK_EN: a zero divisor completes at once with div_zero set.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] d, v, d_nxt;
  logic [WIDTH:0]   p, p_sh, t, p_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, zero_go, last;

  // The DONE cycle also samples start, so back-to-back operations issue every WIDTH+1 cycles.
  assign accept = start && (state == IDLE || state == DONE);
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign zero_go = accept && (divisor == '0);
`else
  assign zero_go = 1'b0;
`endif
  assign last = (state == RUN) && (cnt == CW'(1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? (zero_go ? DONE : RUN) : IDLE;
      RUN:        if (last) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the difference unless it borrowed.
  always_comb begin
    p_sh  = {p[WIDTH-1:0], d[WIDTH-1]};
    t     = p_sh - {1'b0, v};
    p_nxt = t[WIDTH] ? p_sh : t;
    d_nxt = {d[WIDTH-2:0], ~t[WIDTH]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      d         <= '0;
      v         <= '0;
      p         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= next_state;
      if (accept && !zero_go) begin
        d   <= dividend;
        v   <= divisor;
        p   <= '0;
        cnt <= CW'(WIDTH);
      end else if (state == RUN) begin
        d   <= d_nxt;
        p   <= p_nxt;
        cnt <= cnt - CW'(1);
        if (last) begin
          quotient  <= d_nxt;
          remainder <= p_nxt[WIDTH-1:0];
        end
      end
      if (zero_go) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end
  end

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic dz;
  always_ff @(posedge clock) begin
    if (!reset_n)     dz <= 1'b0;
    else if (zero_go) dz <= 1'b1;
    else if (last)    dz <= 1'b0;
  end
  assign div_zero = dz;
`else
  assign div_zero = 1'b0;
`endif

endmodule
